// File: rtl/btn_event_arbiter_pkg.sv
// Shared constant helpers for the button event arbiter.
package btn_event_arbiter_pkg;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/btn_event_arbiter_if.sv
// Event handshake between the arbiter (master) and its consumer (slave).
interface btn_event_arbiter_if #(
   parameter int IDX_W = 2
);
   logic             evt_valid;
   logic             evt_ready;
   logic [IDX_W-1:0] evt_idx;

   modport master (output evt_valid, output evt_idx, input evt_ready);
   modport slave  (input evt_valid, input evt_idx, output evt_ready);
endinterface

// File: rtl/btn_event_arbiter_conditioner.sv
// One button channel: 2-FF synchronizer, debounce counter, registered press pulse.
module btn_conditioner
   import btn_event_arbiter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   output logic press
);
   localparam int             CNT_W   = clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q, s2_q, db_q, db_dly_q, press_q;
   logic             db_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The counter only runs while the synchronized level disagrees with db.
   always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (s2_q != db_q) begin
         if (cnt_q == CNT_MAX) db_d  = s2_q;
         else                  cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         db_q     <= 1'b0;
         db_dly_q <= 1'b0;
         press_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         s1_q     <= btn_in;
         s2_q     <= s1_q;
         db_q     <= db_d;
         cnt_q    <= cnt_d;
         db_dly_q <= db_q;
         press_q  <= db_q & ~db_dly_q;
      end
   end

   assign press = press_q;
endmodule

// File: rtl/btn_event_arbiter.sv
// Conditions N buttons and serves their press events round-robin over a valid/ready port.
module btn_event_arbiter
   import btn_event_arbiter_pkg::*;
#(
   parameter int N               = 4,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         btn_in,
   btn_event_arbiter_if.master  evt_if,
   output logic [N-1:0]         pending,
   output logic [N-1:0]         overflow
);
   localparam int IDX_W = (clog2(N) < 1) ? 1 : clog2(N);

   logic [N-1:0]     press, grant;
   logic [N-1:0]     pending_q, pending_d, overflow_q, overflow_d;
   logic [IDX_W-1:0] idx_q, idx_d, ptr_q, ptr_d, sel, cand;
   logic             valid_q, valid_d, found, load;

   for (genvar g = 0; g < N; g++) begin : g_cond
      btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
         .clk    (clk),
         .rst_n  (rst_n),
         .btn_in (btn_in[g]),
         .press  (press[g])
      );
   end

   assign load = ~valid_q | evt_if.evt_ready;

   // First pending channel at or after ptr, wrapping modulo N.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         cand = IDX_W'((int'(ptr_q) + k) % N);
         if (!found && pending_q[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end

      grant   = '0;
      valid_d = valid_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      if (load) begin
         valid_d = found;
         if (found) begin
            grant[sel] = 1'b1;
            idx_d      = sel;
            ptr_d      = IDX_W'((int'(sel) + 1) % N);
         end
      end

      // A press landing on its own grant cycle re-arms pending without flagging a merge.
      pending_d  = press | (pending_q & ~grant);
      overflow_d = press & pending_q & ~grant;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q  <= '0;
         overflow_q <= '0;
         valid_q    <= 1'b0;
         idx_q      <= '0;
         ptr_q      <= '0;
      end else begin
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         valid_q    <= valid_d;
         idx_q      <= idx_d;
         ptr_q      <= ptr_d;
      end
   end

   assign evt_if.evt_valid = valid_q;
   assign evt_if.evt_idx   = idx_q;
   assign pending          = pending_q;
   assign overflow         = overflow_q;
endmodule

// File: tb/tb_btn_event_arbiter.sv
// Scenario bench for btn_event_arbiter with a randomized press/backpressure soak.
module tb_btn_event_arbiter;
   import btn_event_arbiter_pkg::*;

   localparam int N     = 4;
   localparam int D     = 16;
   localparam int IDX_W = (clog2(N) < 1) ? 1 : clog2(N);

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] btn_in = '0;
   logic [N-1:0] pending, overflow;

   btn_event_arbiter_if #(.IDX_W(IDX_W)) evt_if();

   btn_event_arbiter #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_in   (btn_in),
      .evt_if   (evt_if),
      .pending  (pending),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int acc_cnt[N];
   int ovf_cnt[N];
   int acc_q[$];
   int acc_cyc[$];
   int stall_viol;
   int pend_seen;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_stats();
      for (int i = 0; i < N; i++) begin
         acc_cnt[i] = 0;
         ovf_cnt[i] = 0;
      end
      acc_q.delete();
      acc_cyc.delete();
      stall_viol = 0;
      pend_seen  = 0;
   endtask

   // One clock; logs what the edge accepts and checks backpressure stability.
   task automatic tick();
      logic             stall;
      logic [IDX_W-1:0] held_idx;
      if (rst_n && evt_if.evt_valid && evt_if.evt_ready) begin
         acc_cnt[evt_if.evt_idx]++;
         acc_q.push_back(int'(evt_if.evt_idx));
         acc_cyc.push_back(cyc);
      end
      stall    = rst_n && evt_if.evt_valid && !evt_if.evt_ready;
      held_idx = evt_if.evt_idx;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) if (overflow[i]) ovf_cnt[i]++;
      if (|pending) pend_seen++;
      if (stall && rst_n && (evt_if.evt_valid !== 1'b1 || evt_if.evt_idx !== held_idx))
         stall_viol++;
   endtask

   task automatic apply_reset();
      btn_in = '0;
      evt_if.evt_ready = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_stats();
   endtask

   task automatic hold_btn(input int ch, input int hi, input int lo);
      btn_in[ch] = 1'b1;
      repeat (hi) tick();
      btn_in[ch] = 1'b0;
      repeat (lo) tick();
   endtask

   task automatic test_reset();
      int first_v;
      btn_in = 4'b1000;
      evt_if.evt_ready = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", evt_if.evt_valid); end
      n_checks++; if (evt_if.evt_idx !== '0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", evt_if.evt_idx); end
      n_checks++; if (pending !== '0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", pending); end
      n_checks++; if (overflow !== '0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      rst_n = 1'b1;
      clear_stats();
      first_v = -1;
      for (int t = 1; t <= D + 20; t++) begin
         tick();
         if (evt_if.evt_valid && first_v < 0) first_v = t;
      end
      n_checks++; if (first_v != D + 5) begin n_fail++; $display("FAIL held_at_reset_latency: got %0d want %0d", first_v, D + 5); end
      n_checks++; if (acc_q.size() != 1 || acc_cnt[3] != 1) begin n_fail++; $display("FAIL held_at_reset_count: got %0d events (ch3 %0d) want 1", acc_q.size(), acc_cnt[3]); end
      btn_in = '0;
   endtask

   task automatic test_single_press();
      int first_v, first_p, nvalid, idx_at;
      apply_reset();
      evt_if.evt_ready = 1'b1;
      btn_in[2] = 1'b1;
      first_v = -1; first_p = -1; nvalid = 0; idx_at = -1;
      for (int t = 1; t <= D + 10; t++) begin
         tick();
         if (evt_if.evt_valid) begin
            nvalid++;
            if (first_v < 0) begin first_v = t; idx_at = int'(evt_if.evt_idx); end
         end
         if (pending[2] && first_p < 0) first_p = t;
      end
      n_checks++; if (first_v != D + 5) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", first_v, D + 5); end
      n_checks++; if (idx_at != 2) begin n_fail++; $display("FAIL single_idx: got %0d want 2", idx_at); end
      n_checks++; if (nvalid != 1) begin n_fail++; $display("FAIL single_valid_len: got %0d want 1", nvalid); end
      n_checks++; if (first_p != D + 4) begin n_fail++; $display("FAIL single_pending_time: got %0d want %0d", first_p, D + 4); end
      n_checks++; if (pending !== '0) begin n_fail++; $display("FAIL single_pending_clear: got %b want 0", pending); end
      btn_in = '0;
      repeat (D + 10) tick();
      n_checks++; if (acc_q.size() != 1) begin n_fail++; $display("FAIL single_release_silent: got %0d events want 1", acc_q.size()); end
   endtask

   task automatic test_glitch();
      apply_reset();
      evt_if.evt_ready = 1'b1;
      hold_btn(0, D - 6, 3 * D);
      n_checks++; if (acc_q.size() != 0 || pend_seen != 0) begin n_fail++; $display("FAIL glitch_rejected: got %0d events %0d pending cycles want 0", acc_q.size(), pend_seen); end
      hold_btn(0, D, 4 * D);
      n_checks++; if (acc_q.size() != 1 || acc_cnt[0] != 1) begin n_fail++; $display("FAIL glitch_min_accept: got %0d events want 1", acc_q.size()); end
   endtask

   // Expected order: set bits of mask visited from p upward, wrapping modulo N.
   task automatic rr_expect(input logic [N-1:0] mask, inout int p, output int exp_q[$]);
      exp_q.delete();
      for (int k = 0; k < N; k++) if (mask[(p + k) % N]) exp_q.push_back((p + k) % N);
      if (exp_q.size() > 0) p = (exp_q[exp_q.size() - 1] + 1) % N;
   endtask

   task automatic test_simultaneous();
      int p;
      int exp_q[$];
      apply_reset();
      evt_if.evt_ready = 1'b1;
      p = 0;
      rr_expect(4'b1011, p, exp_q);
      btn_in = 4'b1011;
      repeat (D + 10) tick();
      n_checks++; if (acc_q != exp_q) begin n_fail++; $display("FAIL simul_order: got %p want %p", acc_q, exp_q); end
      n_checks++; if (acc_cyc.size() != 3 || acc_cyc[2] - acc_cyc[0] != 2) begin n_fail++; $display("FAIL simul_back_to_back: got cycles %p want 3 consecutive", acc_cyc); end
      n_checks++; if (evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL simul_drained: got %b want 0", evt_if.evt_valid); end
      btn_in = '0;
      repeat (2 * D) tick();
      acc_q.delete();
      rr_expect(4'b1001, p, exp_q);
      btn_in = 4'b1001;
      repeat (D + 10) tick();
      n_checks++; if (acc_q != exp_q) begin n_fail++; $display("FAIL simul_repeat_order: got %p want %p", acc_q, exp_q); end
      btn_in = '0;
   endtask

   task automatic test_backpressure();
      apply_reset();
      for (int r = 0; r < 3; r++) hold_btn(1, D + 9, D + 9);
      n_checks++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_idx !== IDX_W'(1)) begin n_fail++; $display("FAIL bp_presented: got valid %b idx %0d want 1/1", evt_if.evt_valid, evt_if.evt_idx); end
      n_checks++; if (ovf_cnt[1] != 1) begin n_fail++; $display("FAIL bp_overflow_once: got %0d pulses want 1", ovf_cnt[1]); end
      n_checks++; if (pending !== 4'b0010) begin n_fail++; $display("FAIL bp_pending: got %b want 0010", pending); end
      evt_if.evt_ready = 1'b1;
      repeat (10) tick();
      n_checks++; if (acc_q.size() != 2 || acc_cnt[1] != 2) begin n_fail++; $display("FAIL bp_release_events: got %0d want 2", acc_q.size()); end
      n_checks++; if (stall_viol != 0) begin n_fail++; $display("FAIL bp_idx_stable: got %0d violations want 0", stall_viol); end
      n_checks++; if (pending !== '0 || evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got pending %b valid %b want 0/0", pending, evt_if.evt_valid); end
   endtask

   task automatic test_press_during_grant();
      apply_reset();
      hold_btn(2, D + 9, D + 9);
      hold_btn(2, D + 9, D + 9);
      btn_in[2] = 1'b1;
      repeat (D + 3) tick();
      evt_if.evt_ready = 1'b1;
      tick();
      n_checks++; if (pending[2] !== 1'b1 || overflow[2] !== 1'b0) begin n_fail++; $display("FAIL pdg_same_cycle: got pending %b overflow %b want 1/0", pending[2], overflow[2]); end
      repeat (10) tick();
      btn_in = '0;
      n_checks++; if (acc_cnt[2] != 3 || acc_q.size() != 3) begin n_fail++; $display("FAIL pdg_events: got %0d want 3", acc_q.size()); end
      n_checks++; if (ovf_cnt[2] != 0) begin n_fail++; $display("FAIL pdg_no_overflow: got %0d want 0", ovf_cnt[2]); end
   endtask

   task automatic test_reset_midop();
      apply_reset();
      hold_btn(0, D + 9, 10);
      btn_in = 4'b0110;
      repeat (D + 9) tick();
      n_checks++; if (evt_if.evt_valid !== 1'b1 || pending !== 4'b0110) begin n_fail++; $display("FAIL midrst_setup: got valid %b pending %b want 1/0110", evt_if.evt_valid, pending); end
      btn_in = '0;
      rst_n = 1'b0;
      #1;
      n_checks++; if (evt_if.evt_valid !== 1'b0 || evt_if.evt_idx !== '0 || pending !== '0 || overflow !== '0) begin n_fail++; $display("FAIL midrst_async: got valid %b idx %0d pending %b overflow %b want all 0", evt_if.evt_valid, evt_if.evt_idx, pending, overflow); end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_stats();
      evt_if.evt_ready = 1'b1;
      repeat (3 * D) tick();
      n_checks++; if (acc_q.size() != 0 || pend_seen != 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d events %0d pending cycles want 0", acc_q.size(), pend_seen); end
   endtask

   task automatic test_random();
      int hold[N];
      int rises[N];
      apply_reset();
      for (int i = 0; i < N; i++) begin
         hold[i]  = $urandom_range(3 * D, 1);
         rises[i] = 0;
      end
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (hold[i] == 0) begin
               btn_in[i] = ~btn_in[i];
               if (btn_in[i]) rises[i]++;
               hold[i] = $urandom_range(3 * D, D + 4);
            end
            hold[i]--;
         end
         evt_if.evt_ready = ($urandom_range(9, 0) < 7);
         tick();
      end
      repeat (D + 4) tick();
      btn_in = '0;
      evt_if.evt_ready = 1'b1;
      repeat (4 * D) tick();
      for (int i = 0; i < N; i++) begin
         n_checks++;
         if (acc_cnt[i] + ovf_cnt[i] != rises[i]) begin
            n_fail++;
            $display("FAIL rand_conservation ch%0d: got %0d delivered + %0d merged want %0d presses", i, acc_cnt[i], ovf_cnt[i], rises[i]);
         end
      end
      n_checks++; if (stall_viol != 0) begin n_fail++; $display("FAIL rand_idx_stable: got %0d violations want 0", stall_viol); end
      n_checks++; if (pending !== '0 || evt_if.evt_valid !== 1'b0) begin n_fail++; $display("FAIL rand_drained: got pending %b valid %b want 0/0", pending, evt_if.evt_valid); end
   endtask

   initial begin
      evt_if.evt_ready = 1'b0;
      clear_stats();
      test_reset();
      test_single_press();
      test_glitch();
      test_simultaneous();
      test_backpressure();
      test_press_during_grant();
      test_reset_midop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
